// File: rtl/multi_beat_generator.sv
// multi_beat_generator
//   Parametrised beat sequencer for the control unit. While running it walks a
//   one-hot beat vector through BEATS beats; each beat lasts BEAT_CYCLES clocks
//   unless it is stretched by wait_req. A cycle that has started always
//   finishes. At the end of each cycle the completed-cycle counter increments
//   and cycle_done pulses for one clock.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   run        in   start request; level; 0 = stop after the current cycle
//   single     in   1 = stop after the current cycle (single-step)
//   wait_req   in   1 = freeze the current beat
//   t          out  one-hot beat vector, zero when idle
//   beat_idx   out  binary index of the active beat, 0 when idle
//   busy       out  1 while running
//   cycle_done out  one-clock pulse after each completed cycle
//   cycle_cnt  out  completed-cycle count, wraps
module multi_beat_generator #(
  parameter int BEATS       = 4,
  parameter int BEAT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     run,
  input  logic                                     single,
  input  logic                                     wait_req,
  output logic [BEATS-1:0]                         t,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] beat_idx,
  output logic                                     busy,
  output logic                                     cycle_done,
  output logic [CNT_W-1:0]                         cycle_cnt
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUB_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(BEAT_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [BEATS-1:0] r_t;
  logic [IDX_W-1:0] r_beat_idx;
  logic [SUB_W-1:0] r_sub;
  logic             r_busy;
  logic             r_cycle_done;
  logic [CNT_W-1:0] r_cycle_cnt;

  // Last clock of the last beat with no stall: this edge closes the cycle.
  logic w_beat_end;
  logic w_cycle_end;
  assign w_beat_end  = (r_sub == LAST_SUB);
  assign w_cycle_end = w_beat_end && (r_beat_idx == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_t          <= '0;
      r_beat_idx   <= '0;
      r_sub        <= '0;
      r_busy       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_cycle_cnt  <= '0;
    end else begin
      r_cycle_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // single is deliberately not looked at here: run is the start
          // request in both modes.
          if (run) begin
            r_state    <= RUN;
            r_t        <= BEATS'(1);
            r_beat_idx <= '0;
            r_sub      <= '0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (!wait_req) begin
            if (!w_beat_end) begin
              r_sub <= r_sub + SUB_W'(1);
            end else if (w_cycle_end) begin
              r_sub        <= '0;
              r_beat_idx   <= '0;
              r_cycle_cnt  <= r_cycle_cnt + CNT_W'(1);
              r_cycle_done <= 1'b1;
              // run/single only matter at this edge; mid-cycle changes never
              // cut a cycle short.
              if (run && !single) begin
                r_t <= BEATS'(1);
              end else begin
                r_state <= IDLE;
                r_t     <= '0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_sub      <= '0;
              r_t        <= {r_t[BEATS-2:0], r_t[BEATS-1]};
              r_beat_idx <= r_beat_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_t     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign t          = r_t;
  assign beat_idx   = r_beat_idx;
  assign busy       = r_busy;
  assign cycle_done = r_cycle_done;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: doc/multi_beat_generator.md
Name: multi_beat_generator

Overview:
- Parametrised successor of the fixed four-beat timing generator.
- Produces a one-hot beat vector `t` that sequences the CPU's per-instruction phases.
- Adds configurable beat count and beat length, wait-state stretching, graceful stop, single-cycle stepping, and an instruction-cycle counter.
- Sits between the clock/reset source and the control unit; the control unit qualifies every micro-operation with `t`.

Parameters:
- BEATS, 4, number of beats per instruction cycle; width of `t`; ≥2.
- BEAT_CYCLES, 1, clock cycles each beat lasts when not stalled; ≥1.
- CNT_W, 16, width of the completed-instruction-cycle counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = generate cycles; 0 = stop after the current cycle completes.
- single  in  1  level; 1 = stop after the current cycle completes (single-step mode).
- wait_req  in  1  level; 1 freezes the current beat (memory/IO wait state).
- t  out  BEATS  one-hot beat vector; all zero when idle.
- beat_idx  out  clog2(BEATS)  binary index of the active beat; 0 when idle.
- busy  out  1  1 while in RUN.
- cycle_done  out  1  one-clock pulse after each completed instruction cycle.
- cycle_cnt  out  CNT_W  count of completed cycles; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous, any time, including mid-beat):
  - state=IDLE, t=0, beat_idx=0, busy=0, cycle_done=0, cycle_cnt=0.
  - Internal sub-beat counter cleared.
  - Release is synchronous to the next clk edge.
- States: IDLE, RUN.
- IDLE:
  - t=0, busy=0.
  - When run=1 at a rising edge: go to RUN, t=1 (beat 0), beat_idx=0, sub=0.
  - Latency is one clock from run sampled high to t[0] high.
  - `single` is ignored while in IDLE; `run` is the start request in both modes.
- RUN, stalled (wait_req=1): t, beat_idx and sub hold unchanged; wait_req may stretch any beat indefinitely.
- RUN, not stalled:
  - If sub<BEAT_CYCLES-1: sub increments.
  - Else sub returns to 0 and the beat advances: t rotates left by one, beat_idx increments.
- End of cycle (advance out of beat BEATS-1, i.e. beat_idx=BEATS-1, sub=BEAT_CYCLES-1, wait_req=0):
  - cycle_cnt increments; it wraps from all-ones to 0 with no flag.
  - cycle_done=1 for exactly the following clock.
  - If run=1 and single=0: t wraps to beat 0 with no gap cycle (back-to-back cycles).
  - If run=0 or single=1: go to IDLE, t=0, busy=0.
- run or single changing mid-cycle never truncates the current cycle; only their value at the end-of-cycle edge matters.
- In single mode, each run assertion seen in IDLE yields exactly one full cycle. If run is still 1 when IDLE is re-entered, the next cycle starts one clock later.
- A single-beat-cycle machine is impossible (BEATS≥2). For BEAT_CYCLES=1, sub is constant 0.
- Invariant: t is always one-hot in RUN and zero in IDLE; t[beat_idx]=1 whenever busy=1.
- cycle_done and cycle_cnt are unaffected by wait_req except through the delayed end of cycle.

Test Plan:
- Default params, reset pulse, run=1 held, 20 clocks:
  - t sequence 0001,0010,0100,1000,0001… starting one clock after run is sampled.
  - cycle_done pulses every 4 clocks, coincident with each return to t=0001.
  - cycle_cnt reads 1,2,3… after each pulse.
- BEAT_CYCLES=3, BEATS=6: each t value holds exactly 3 clocks; full cycle is 18 clocks; t wraps from 100000 to 000001.
- wait_req=1 for 5 clocks during beat 2 (default params): t=0100 holds 6 clocks total; cycle_done is delayed by 5 clocks; cycle_cnt is still correct.
- Stop and step:
  - Drop run during beat 1: beats 2 and 3 still occur, then t=0, busy=0, cycle_done=1 once.
  - With single=1 and run pulsed for 1 clock: exactly one 4-beat cycle, then IDLE.
- Reset mid-beat:
  - Assert rst=0 asynchronously between edges while t=0100: all outputs go to zero immediately, without waiting for an edge.
  - Release with run=1: t=0001 on the first edge after release.
- CNT_W=3, 9 cycles: cycle_cnt reads 7 then wraps to 0, then 1; no other effect.
